// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a five-stage MIPS pipeline.
// Keeps shadow ID/EX, EX/MEM and MEM/WB register fields and derives EX operand selects.
module fwd_hazard_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic [REG_W-1:0] idex_rs_q, idex_rs_d;
    logic [REG_W-1:0] idex_rt_q, idex_rt_d;
    logic [REG_W-1:0] idex_dest_q, idex_dest_d;
    logic             idex_rw_q, idex_rw_d;
    logic             idex_mr_q, idex_mr_d;
    logic [REG_W-1:0] exmem_dest_q, exmem_dest_d;
    logic             exmem_rw_q, exmem_rw_d;
    logic [REG_W-1:0] memwb_dest_q, memwb_dest_d;
    logic             memwb_rw_q, memwb_rw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble;

    // Nearer producer (EX/MEM) wins; register 0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic [REG_W-1:0] mem_dest,
                                           input logic             mem_rw,
                                           input logic [REG_W-1:0] wb_dest,
                                           input logic             wb_rw);
        logic [1:0] sel;
        sel = SEL_RF;
        if (mem_rw && (mem_dest != '0) && (mem_dest == src)) begin
            sel = SEL_MEM;
        end else if (wb_rw && (wb_dest != '0) && (wb_dest == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        stall = idex_mr_q && (idex_dest_q != '0) && id_valid &&
                ((idex_dest_q == id_rs) || (idex_dest_q == id_rt));
        forward_a = fwd_sel(idex_rs_q, exmem_dest_q, exmem_rw_q, memwb_dest_q, memwb_rw_q);
        forward_b = fwd_sel(idex_rt_q, exmem_dest_q, exmem_rw_q, memwb_dest_q, memwb_rw_q);
        stall_count = cnt_q;
    end

    // Pipeline advance; a stall, flush or empty ID slot enters EX as an all-zero bubble.
    always_comb begin
        bubble       = stall || flush || !id_valid;
        idex_rs_d    = bubble ? '0 : id_rs;
        idex_rt_d    = bubble ? '0 : id_rt;
        idex_dest_d  = bubble ? '0 : id_dest;
        idex_rw_d    = bubble ? 1'b0 : id_regwrite;
        idex_mr_d    = bubble ? 1'b0 : id_memread;
        exmem_dest_d = idex_dest_q;
        exmem_rw_d   = idex_rw_q;
        memwb_dest_d = exmem_dest_q;
        memwb_rw_d   = exmem_rw_q;
        cnt_d        = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_dest_q  <= '0;
            idex_rw_q    <= 1'b0;
            idex_mr_q    <= 1'b0;
            exmem_dest_q <= '0;
            exmem_rw_q   <= 1'b0;
            memwb_dest_q <= '0;
            memwb_rw_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_dest_q  <= idex_dest_d;
            idex_rw_q    <= idex_rw_d;
            idex_mr_q    <= idex_mr_d;
            exmem_dest_q <= exmem_dest_d;
            exmem_rw_q   <= exmem_rw_d;
            memwb_dest_q <= memwb_dest_d;
            memwb_rw_q   <= memwb_rw_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: each row drives one ID slot and queues
// the outputs expected while that slot is presented.
module tb_fwd_hazard_unit;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic [REG_W-1:0] id_dest = '0;
    logic             id_regwrite = 1'b0;
    logic             id_memread = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] d;
        logic             rw;
        logic             mr;
        logic             fl;
        exp_t             e;
    } row_t;

    exp_t exp_q[$];

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic v, input int rs, input int rt, input int d,
                                input logic rw, input logic mr, input logic fl,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic st, input int cnt);
        row_t r;
        r.v = v; r.rs = REG_W'(rs); r.rt = REG_W'(rt); r.d = REG_W'(d);
        r.rw = rw; r.mr = mr; r.fl = fl;
        r.e.fa = fa; r.e.fb = fb; r.e.st = st; r.e.cnt = CNT_W'(cnt);
        return r;
    endfunction

    function automatic row_t bub(input logic [1:0] fa, input logic [1:0] fb, input int cnt);
        return mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, fa, fb, 1'b0, cnt);
    endfunction

    // Present one ID slot just after the edge and queue what it should produce.
    task automatic drive(input row_t r);
        @(posedge clk);
        #1;
        reset = 1'b0;
        id_valid = r.v; id_rs = r.rs; id_rt = r.rt; id_dest = r.d;
        id_regwrite = r.rw; id_memread = r.mr; flush = r.fl;
        exp_q.push_back(r.e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e, got;
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            id_valid = 1'b1; id_rs = REG_W'($urandom); id_rt = REG_W'($urandom);
            id_dest = REG_W'($urandom); id_regwrite = 1'($urandom);
            id_memread = 1'($urandom); flush = 1'($urandom);
        end
        rows.push_back(bub(2'b00, 2'b00, 0));
        rows.push_back(mk(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got = {forward_a, forward_b, stall, stall_count};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset row %0d: got fa=%b fb=%b st=%b cnt=%0d, exp fa=%b fb=%b st=%b cnt=%0d",
                         i, got.fa, got.fb, got.st, got.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
        do_reset();
        rows.delete();
        rows.push_back(mk(1, 3, 3, 4, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        rows.push_back(bub(2'b00, 2'b00, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got = {forward_a, forward_b, stall, stall_count};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_midflight row %0d: got fa=%b fb=%b st=%b cnt=%0d, exp fa=%b fb=%b st=%b cnt=%0d",
                         i, got.fa, got.fb, got.st, got.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_ex_mem_forward();
        row_t rows[$];
        exp_t e, got;
        do_reset();
        rows.push_back(mk(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0));   // add $3,$1,$2
        rows.push_back(mk(1, 3, 5, 4, 1, 0, 0, 2'b00, 2'b00, 0, 0));   // sub $4,$3,$5
        rows.push_back(mk(1, 7, 3, 6, 1, 0, 0, 2'b10, 2'b00, 0, 0));   // or $6,$7,$3
        rows.push_back(bub(2'b00, 2'b01, 0));
        rows.push_back(mk(1, 1, 2, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0));  // add $10
        rows.push_back(bub(2'b00, 2'b00, 0));
        rows.push_back(bub(2'b00, 2'b00, 0));
        rows.push_back(mk(1, 10, 10, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        rows.push_back(bub(2'b00, 2'b00, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got = {forward_a, forward_b, stall, stall_count};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL ex_mem_forward row %0d: got fa=%b fb=%b st=%b cnt=%0d, exp fa=%b fb=%b st=%b cnt=%0d",
                         i, got.fa, got.fb, got.st, got.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_double_hazard();
        row_t rows[$];
        exp_t e, got;
        do_reset();
        rows.push_back(mk(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        rows.push_back(mk(1, 4, 5, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        rows.push_back(mk(1, 3, 3, 8, 1, 0, 0, 2'b00, 2'b00, 0, 0));   // and $8,$3,$3
        rows.push_back(bub(2'b10, 2'b10, 0));
        rows.push_back(mk(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        rows.push_back(mk(1, 0, 0, 3, 0, 0, 0, 2'b00, 2'b00, 0, 0));   // non-writing dest $3
        rows.push_back(mk(1, 3, 0, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        rows.push_back(bub(2'b01, 2'b00, 0));
        rows.push_back(bub(2'b00, 2'b00, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got = {forward_a, forward_b, stall, stall_count};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL double_hazard row %0d: got fa=%b fb=%b st=%b cnt=%0d, exp fa=%b fb=%b st=%b cnt=%0d",
                         i, got.fa, got.fb, got.st, got.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        row_t rows[$];
        exp_t e, got;
        int c0, c1;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            c0 = (k < 15) ? k : 15;
            c1 = (k + 1 < 15) ? k + 1 : 15;
            rows.push_back(mk(1, 1, 2, 2, 1, 1, 0, (k == 0) ? 2'b00 : 2'b01, 2'b00, 0, c0));
            rows.push_back(mk(1, 2, 5, 4, 1, 0, 0, 2'b00, 2'b00, 1, c0));
            rows.push_back(mk(1, 2, 5, 4, 1, 0, 0, 2'b00, 2'b00, 0, c1));
        end
        rows.push_back(bub(2'b01, 2'b00, 15));
        rows.push_back(bub(2'b00, 2'b00, 15));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got = {forward_a, forward_b, stall, stall_count};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL saturation row %0d: got fa=%b fb=%b st=%b cnt=%0d, exp fa=%b fb=%b st=%b cnt=%0d",
                         i, got.fa, got.fb, got.st, got.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        exp_t e, got;
        do_reset();
        rows.push_back(mk(1, 1, 2, 2, 1, 1, 0, 2'b00, 2'b00, 0, 0));   // lw $2,0($1)
        rows.push_back(mk(1, 2, 5, 4, 1, 0, 0, 2'b00, 2'b00, 1, 0));   // add $4,$2,$5
        rows.push_back(mk(1, 2, 5, 4, 1, 0, 0, 2'b00, 2'b00, 0, 1));   // held, bubble in EX
        rows.push_back(bub(2'b01, 2'b00, 1));
        rows.push_back(bub(2'b00, 2'b00, 1));
        rows.push_back(mk(1, 1, 7, 7, 1, 1, 0, 2'b00, 2'b00, 0, 1));   // lw $7
        rows.push_back(mk(1, 0, 7, 8, 1, 0, 1, 2'b00, 2'b00, 1, 1));   // use + flush
        rows.push_back(bub(2'b00, 2'b00, 2));
        rows.push_back(bub(2'b00, 2'b00, 2));
        rows.push_back(mk(1, 1, 7, 7, 1, 1, 0, 2'b00, 2'b00, 0, 2));
        rows.push_back(mk(0, 0, 7, 8, 1, 0, 0, 2'b00, 2'b00, 0, 2));   // invalid slot never stalls
        rows.push_back(bub(2'b00, 2'b00, 2));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got = {forward_a, forward_b, stall, stall_count};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL load_use row %0d: got fa=%b fb=%b st=%b cnt=%0d, exp fa=%b fb=%b st=%b cnt=%0d",
                         i, got.fa, got.fb, got.st, got.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_zero_flush();
        row_t rows[$];
        exp_t e, got;
        do_reset();
        rows.push_back(mk(1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0));   // lw $0
        rows.push_back(mk(1, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0));   // use of $0
        rows.push_back(bub(2'b00, 2'b00, 0));
        rows.push_back(bub(2'b00, 2'b00, 0));
        rows.push_back(mk(1, 1, 2, 9, 1, 0, 1, 2'b00, 2'b00, 0, 0));   // flushed writer of $9
        rows.push_back(mk(1, 9, 9, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        rows.push_back(bub(2'b00, 2'b00, 0));
        rows.push_back(bub(2'b00, 2'b00, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            got = {forward_a, forward_b, stall, stall_count};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL zero_flush row %0d: got fa=%b fb=%b st=%b cnt=%0d, exp fa=%b fb=%b st=%b cnt=%0d",
                         i, got.fa, got.fb, got.st, got.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_mem_forward();
        test_double_hazard();
        test_saturation();
        test_load_use();
        test_zero_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
